// File: rtl/simd_merge_feeder_if.sv
// rtl/simd_merge_feeder_if.sv - source, merger and output signal bundle for simd_merge_feeder
interface simd_merge_feeder_if;
    logic         a_v;
    logic [255:0] a_data;
    logic         a_last;
    logic         a_ready;
    logic         b_v;
    logic [255:0] b_data;
    logic         b_last;
    logic         b_ready;
    logic         m_in_v;
    logic [255:0] m_in8A;
    logic [255:0] m_in8B;
    logic [4:0]   m_rd;
    logic [2:0]   m_vrd1;
    logic [2:0]   m_vrd2;
    logic         m_out_v;
    logic [255:0] m_out8A;
    logic         m_next_source_v;
    logic         m_next_source;
    logic         m_not_accepting;
    logic         m_reset;
    logic         o_v;
    logic [255:0] o_data;
    logic         o_last;
    logic         o_ready;
    logic         busy;

    modport slave (
        input  a_v, a_data, a_last, b_v, b_data, b_last,
        input  m_out_v, m_out8A, m_next_source_v, m_next_source, m_not_accepting,
        input  o_ready,
        output a_ready, b_ready,
        output m_in_v, m_in8A, m_in8B, m_rd, m_vrd1, m_vrd2, m_reset,
        output o_v, o_data, o_last, busy
    );

    modport master (
        output a_v, a_data, a_last, b_v, b_data, b_last,
        output m_out_v, m_out8A, m_next_source_v, m_next_source, m_not_accepting,
        output o_ready,
        input  a_ready, b_ready,
        input  m_in_v, m_in8A, m_in8B, m_rd, m_vrd1, m_vrd2, m_reset,
        input  o_v, o_data, o_last, busy
    );
endinterface

// File: rtl/simd_merge_feeder.sv
// rtl/simd_merge_feeder.sv - feeds two sorted vector streams through the merger unit, one op in flight
module simd_merge_feeder_fifo #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn_i,
    input  logic         push_i,
    input  logic [255:0] data_i,
    input  logic         last_i,
    input  logic         pop_i,
    output logic         ready_o,
    output logic         empty_o,
    output logic [255:0] head_data_o,
    output logic         head_last_o
);
    localparam int AW = $clog2(DEPTH);

    logic [255:0] mem_q [DEPTH];
    logic         lst_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign ready_o     = cnt_q != (AW+1)'(DEPTH);
    assign empty_o     = cnt_q == '0;
    assign push_ok     = push_i && ready_o;
    assign pop_ok      = pop_i && !empty_o;
    assign head_data_o = mem_q[rd_q];
    assign head_last_o = lst_q[rd_q];

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                lst_q[wr_q] <= last_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

module simd_merge_feeder #(
    parameter int         DEPTH  = 4,
    parameter logic [4:0] RD_TAG = 5'd1,
    parameter logic [2:0] VRD1   = 3'd1,
    parameter logic [2:0] VRD2   = 3'd2
) (
    input logic                 clk,
    input logic                 reset,
    simd_merge_feeder_if.slave  bus
);
    localparam logic [255:0] SENTINEL = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FIRST, S_ISSUE, S_WAIT, S_LAST, S_WAIT_LAST
    } state_e;

    state_e       state_q, state_d;
    logic         inflight_q, inflight_d;
    logic         a_exh_q, a_exh_d, b_exh_q, b_exh_d;
    logic         m_in_v_q, m_in_v_d;
    logic [255:0] m_in8a_q, m_in8a_d, m_in8b_q, m_in8b_d;
    logic [4:0]   m_rd_q, m_rd_d;
    logic         o_v_q, o_v_d, o_last_q, o_last_d;
    logic [255:0] o_data_q, o_data_d;

    logic         a_pop, b_pop, a_empty, b_empty, a_head_last, b_head_last;
    logic [255:0] a_head, b_head, head_a, head_b;
    logic         can_issue, ns_ev, out_ev, accept;

    simd_merge_feeder_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rstn_i(reset), .push_i(bus.a_v), .data_i(bus.a_data), .last_i(bus.a_last),
        .pop_i(a_pop), .ready_o(bus.a_ready), .empty_o(a_empty),
        .head_data_o(a_head), .head_last_o(a_head_last)
    );

    simd_merge_feeder_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rstn_i(reset), .push_i(bus.b_v), .data_i(bus.b_data), .last_i(bus.b_last),
        .pop_i(b_pop), .ready_o(bus.b_ready), .empty_o(b_empty),
        .head_data_o(b_head), .head_last_o(b_head_last)
    );

    // Exhausted sources present +inf lanes so the merger never selects them again.
    assign head_a    = a_exh_q ? SENTINEL : a_head;
    assign head_b    = b_exh_q ? SENTINEL : b_head;
    assign can_issue = !inflight_q && !bus.m_not_accepting && !o_v_q
                       && (a_exh_q || !a_empty) && (b_exh_q || !b_empty);
    assign ns_ev     = bus.m_next_source_v && inflight_q;
    assign out_ev    = bus.m_out_v && inflight_q;
    assign accept    = o_v_q && bus.o_ready;

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        a_exh_d    = a_exh_q;
        b_exh_d    = b_exh_q;
        m_in_v_d   = 1'b0;
        m_in8a_d   = m_in8a_q;
        m_in8b_d   = m_in8b_q;
        m_rd_d     = m_rd_q;
        o_v_d      = o_v_q && !accept;
        o_data_d   = o_data_q;
        o_last_d   = o_last_q && !accept;
        a_pop      = 1'b0;
        b_pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!a_empty && !b_empty) begin
                    state_d = S_FIRST;
                    a_exh_d = 1'b0;
                    b_exh_d = 1'b0;
                end
            end
            S_FIRST, S_ISSUE: begin
                if (can_issue) begin
                    m_in_v_d   = 1'b1;
                    inflight_d = 1'b1;
                    m_in8a_d   = head_a;
                    m_in8b_d   = head_b;
                    m_rd_d     = RD_TAG;
                end else if (ns_ev) begin
                    // The opening op consumes both heads regardless of what the merger reports.
                    if (state_q == S_FIRST) begin
                        a_pop = 1'b1;
                        b_pop = 1'b1;
                    end else if (bus.m_next_source) begin
                        b_pop = 1'b1;
                    end else begin
                        a_pop = 1'b1;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (out_ev) begin
                    o_v_d      = 1'b1;
                    o_data_d   = bus.m_out8A;
                    inflight_d = 1'b0;
                    state_d    = (a_exh_q && b_exh_q) ? S_LAST : S_ISSUE;
                end
            end
            S_LAST: begin
                if (can_issue) begin
                    m_in_v_d   = 1'b1;
                    inflight_d = 1'b1;
                    m_in8a_d   = SENTINEL;
                    m_in8b_d   = SENTINEL;
                    m_rd_d     = 5'd0;
                    state_d    = S_WAIT_LAST;
                end
            end
            S_WAIT_LAST: begin
                if (out_ev) begin
                    o_v_d      = 1'b1;
                    o_data_d   = bus.m_out8A;
                    o_last_d   = 1'b1;
                    inflight_d = 1'b0;
                end
                if (accept) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (a_pop && a_head_last) a_exh_d = 1'b1;
        if (b_pop && b_head_last) b_exh_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            inflight_q <= 1'b0;
            a_exh_q    <= 1'b0;
            b_exh_q    <= 1'b0;
            m_in_v_q   <= 1'b0;
            m_in8a_q   <= '0;
            m_in8b_q   <= '0;
            m_rd_q     <= RD_TAG;
            o_v_q      <= 1'b0;
            o_data_q   <= '0;
            o_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            a_exh_q    <= a_exh_d;
            b_exh_q    <= b_exh_d;
            m_in_v_q   <= m_in_v_d;
            m_in8a_q   <= m_in8a_d;
            m_in8b_q   <= m_in8b_d;
            m_rd_q     <= m_rd_d;
            o_v_q      <= o_v_d;
            o_data_q   <= o_data_d;
            o_last_q   <= o_last_d;
        end
    end

    assign bus.m_in_v  = m_in_v_q;
    assign bus.m_in8A  = m_in8a_q;
    assign bus.m_in8B  = m_in8b_q;
    assign bus.m_rd    = m_rd_q;
    assign bus.m_vrd1  = VRD1;
    assign bus.m_vrd2  = VRD2;
    assign bus.m_reset = ~reset;
    assign bus.o_v     = o_v_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_last  = o_last_q;
    assign bus.busy    = state_q != S_IDLE;
endmodule

// File: tb/tb_simd_merge_feeder.sv
// tb/tb_simd_merge_feeder.sv - directed bench with a behavioural merger model
module tb_simd_merge_feeder;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    simd_merge_feeder_if bus();

    simd_merge_feeder #(.DEPTH(4), .RD_TAG(5'd1), .VRD1(3'd1), .VRD2(3'd2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Merger model: keeps the upper 8 keys, emits the lower 8 of each merge.
    logic [255:0] mdl_upper = '0;
    logic [255:0] mdl_res = '0;
    logic         mdl_started = 1'b0;
    int           mdl_t = 0;
    int           mdl_ops = 0;
    logic [4:0]   mdl_rd_log [64];
    logic         mdl_pick_b;
    logic [511:0] mdl_sorted;

    function automatic logic [511:0] sort16(input logic [255:0] x, input logic [255:0] y);
        logic [31:0]  k [16];
        logic [31:0]  t;
        logic [511:0] r;
        for (int i = 0; i < 8; i++) begin
            k[i]   = x[32*i +: 32];
            k[i+8] = y[32*i +: 32];
        end
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 15 - i; j++)
                if (k[j] > k[j+1]) begin
                    t = k[j]; k[j] = k[j+1]; k[j+1] = t;
                end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = k[i];
        return r;
    endfunction

    assign mdl_pick_b = bus.m_in8B[31:0] < bus.m_in8A[31:0];
    assign mdl_sorted = mdl_started ? sort16(mdl_upper, mdl_pick_b ? bus.m_in8B : bus.m_in8A)
                                    : sort16(bus.m_in8A, bus.m_in8B);

    always @(posedge clk) begin
        bus.m_out_v         <= 1'b0;
        bus.m_next_source_v <= 1'b0;
        if (bus.m_reset) begin
            mdl_started         <= 1'b0;
            mdl_t               <= 0;
            bus.m_not_accepting <= 1'b0;
            bus.m_next_source   <= 1'b0;
            bus.m_out8A         <= '0;
        end else if (bus.m_in_v) begin
            mdl_res             <= mdl_sorted[255:0];
            mdl_upper           <= mdl_sorted[511:256];
            mdl_started         <= bus.m_rd != 5'd0;
            bus.m_next_source_v <= 1'b1;
            bus.m_next_source   <= mdl_started && mdl_pick_b;
            bus.m_not_accepting <= 1'b1;
            mdl_t               <= 1;
            mdl_rd_log[mdl_ops[5:0]] <= bus.m_rd;
            mdl_ops             <= mdl_ops + 1;
        end else if (mdl_t != 0) begin
            if (mdl_t == 4) begin
                bus.m_out_v         <= 1'b1;
                bus.m_out8A         <= mdl_res;
                bus.m_not_accepting <= 1'b0;
                mdl_t               <= 0;
            end else begin
                mdl_t <= mdl_t + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] vec(input int base, input int step);
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = 32'(base + step * j);
        return v;
    endfunction

    task automatic push(input bit src_b, input logic [255:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!(src_b ? bus.b_ready : bus.a_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("push_ready_timeout", 256'(0), 256'(1));
        if (src_b) begin
            bus.b_v = 1'b1; bus.b_data = d; bus.b_last = l;
        end else begin
            bus.a_v = 1'b1; bus.a_data = d; bus.a_last = l;
        end
        @(negedge clk);
        bus.a_v = 1'b0;
        bus.b_v = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [255:0] exp, input logic exp_last, input int hold);
        int           n = 0;
        int           ops0;
        logic         stable;
        logic [255:0] d0;
        while (!bus.o_v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check_eq({tag, "_ov_timeout"}, 256'(0), 256'(1));
            return;
        end
        if (hold > 0) begin
            d0     = bus.o_data;
            ops0   = mdl_ops;
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (bus.o_data !== d0 || bus.o_v !== 1'b1) stable = 1'b0;
            end
            check_eq({tag, "_stable"}, 256'(stable), 256'(1));
            check_eq({tag, "_no_issue"}, 256'(mdl_ops), 256'(ops0));
        end
        check_eq({tag, "_data"}, bus.o_data, exp);
        check_eq({tag, "_last"}, 256'(bus.o_last), 256'(exp_last));
        bus.o_ready = 1'b1;
        @(negedge clk);
        bus.o_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, 256'(bus.busy), 256'(0));
    endtask

    task automatic run_t2(input string tag);
        push(1'b0, vec(0, 2), 1'b0);
        push(1'b0, vec(16, 2), 1'b1);
        push(1'b1, vec(1, 2), 1'b0);
        push(1'b1, vec(17, 2), 1'b1);
        collect({tag, "_o0"}, vec(0, 1), 1'b0, 0);
        collect({tag, "_o1"}, vec(8, 1), 1'b0, 0);
        collect({tag, "_o2"}, vec(16, 1), 1'b0, 0);
        collect({tag, "_o3"}, vec(24, 1), 1'b1, 0);
        wait_idle(tag);
    endtask

    initial begin
        int ops0;
        int n;
        reset = 1'b0;
        bus.a_v = 1'b0; bus.a_data = '0; bus.a_last = 1'b0;
        bus.b_v = 1'b0; bus.b_data = '0; bus.b_last = 1'b0;
        bus.o_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_m_in_v", 256'(bus.m_in_v), 256'(0));
        check_eq("rst_o_v", 256'(bus.o_v), 256'(0));
        check_eq("rst_o_last", 256'(bus.o_last), 256'(0));
        check_eq("rst_busy", 256'(bus.busy), 256'(0));
        check_eq("rst_a_ready", 256'(bus.a_ready), 256'(1));
        check_eq("rst_b_ready", 256'(bus.b_ready), 256'(1));
        check_eq("rst_m_rd", 256'(bus.m_rd), 256'(1));
        check_eq("rst_m_in8A", bus.m_in8A, 256'(0));
        check_eq("rst_m_reset", 256'(bus.m_reset), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        check_eq("m_reset_released", 256'(bus.m_reset), 256'(0));

        // T1: two single-vector streams, two merger ops
        ops0 = mdl_ops;
        push(1'b0, vec(0, 1), 1'b1);
        push(1'b1, vec(8, 1), 1'b1);
        collect("t1_o0", vec(0, 1), 1'b0, 0);
        collect("t1_o1", vec(8, 1), 1'b1, 0);
        wait_idle("t1");
        check_eq("t1_ops", 256'(mdl_ops - ops0), 256'(2));
        check_eq("t1_rd0", 256'(mdl_rd_log[ops0 % 64]), 256'(1));
        check_eq("t1_rd1", 256'(mdl_rd_log[(ops0 + 1) % 64]), 256'(0));
        check_eq("t1_final_in8A", bus.m_in8A, {256{1'b1}});
        check_eq("t1_vrd1", 256'(bus.m_vrd1), 256'(1));
        check_eq("t1_vrd2", 256'(bus.m_vrd2), 256'(2));

        // T2: interleaved evens/odds
        ops0 = mdl_ops;
        run_t2("t2");
        check_eq("t2_ops", 256'(mdl_ops - ops0), 256'(4));

        // T3: B exhausts after the first op
        ops0 = mdl_ops;
        push(1'b0, vec(0, 1), 1'b0);
        push(1'b0, vec(8, 1), 1'b0);
        push(1'b0, vec(16, 1), 1'b1);
        push(1'b1, vec(100, 1), 1'b1);
        collect("t3_o0", vec(0, 1), 1'b0, 0);
        collect("t3_o1", vec(8, 1), 1'b0, 0);
        collect("t3_o2", vec(16, 1), 1'b0, 0);
        collect("t3_o3", vec(100, 1), 1'b1, 0);
        wait_idle("t3");
        check_eq("t3_ops", 256'(mdl_ops - ops0), 256'(4));
        check_eq("t3_op1_in8B", bus.m_in8B, {256{1'b1}});

        // T4: consumer stalls 20 cycles on the first output
        push(1'b0, vec(0, 1), 1'b1);
        push(1'b1, vec(8, 1), 1'b1);
        collect("t4_o0", vec(0, 1), 1'b0, 20);
        collect("t4_o1", vec(8, 1), 1'b1, 0);
        wait_idle("t4");

        // T5: reset right after the second merger op, then a clean rerun of T2
        ops0 = mdl_ops;
        push(1'b0, vec(0, 2), 1'b0);
        push(1'b0, vec(16, 2), 1'b1);
        push(1'b1, vec(1, 2), 1'b0);
        push(1'b1, vec(17, 2), 1'b1);
        collect("t5_o0", vec(0, 1), 1'b0, 0);
        n = 0;
        while (mdl_ops < ops0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_second_op", 256'(mdl_ops - ops0), 256'(2));
        check_eq("t5_busy_before", 256'(bus.busy), 256'(1));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("t5_o_v", 256'(bus.o_v), 256'(0));
        check_eq("t5_busy", 256'(bus.busy), 256'(0));
        check_eq("t5_a_ready", 256'(bus.a_ready), 256'(1));
        check_eq("t5_b_ready", 256'(bus.b_ready), 256'(1));
        repeat (8) @(negedge clk);
        check_eq("t5_no_stale_o_v", 256'(bus.o_v), 256'(0));
        run_t2("t5_rerun");

        // T6: B withheld mid-run while not exhausted
        push(1'b0, vec(0, 2), 1'b0);
        push(1'b0, vec(16, 2), 1'b1);
        push(1'b1, vec(1, 2), 1'b0);
        collect("t6_o0", vec(0, 1), 1'b0, 0);
        ops0 = mdl_ops;
        repeat (10) @(negedge clk);
        check_eq("t6_no_issue", 256'(mdl_ops), 256'(ops0));
        check_eq("t6_busy", 256'(bus.busy), 256'(1));
        push(1'b1, vec(17, 2), 1'b1);
        collect("t6_o1", vec(8, 1), 1'b0, 0);
        collect("t6_o2", vec(16, 1), 1'b0, 0);
        collect("t6_o3", vec(24, 1), 1'b1, 0);
        wait_idle("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
